// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: streams operand bits LSB-first into an external full adder.
// Optional SERIAL_ADD_TICK_EN slows stepping to one step every TICK_DIV clocks.
module serial_add_seq #(
    parameter int          WIDTH    = 8,
    parameter logic [23:0] TICK_DIV = 24'd10_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_cin_init,
    output logic             o_fa_a,
    output logic             o_fa_b,
    output logic             o_fa_cin,
    input  logic             i_fa_sum,
    input  logic             i_fa_cout,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out,
    output logic [4:0]       o_bit_idx
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic             r_fa_a;
    logic             r_fa_b;
    logic             r_fa_cin;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic [4:0]       r_bit_idx;

    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [WIDTH-1:0] w_result_next;

`ifdef SERIAL_ADD_TICK_EN
    logic [23:0] r_tick;

    assign w_step = (r_state == S_RUN) && (r_tick == (TICK_DIV - 24'd1));

    // Tick prescaler: counts RUN cycles and wraps on each step edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick <= 24'd0;
        end else if (r_state == S_IDLE) begin
            r_tick <= 24'd0;
        end else if (r_state == S_RUN) begin
            if (w_step) begin
                r_tick <= 24'd0;
            end else begin
                r_tick <= r_tick + 24'd1;
            end
        end else begin
            r_tick <= r_tick;
        end
    end
`else
    logic w_unused_tick_div;

    assign w_unused_tick_div = ^TICK_DIV;
    assign w_step            = (r_state == S_RUN);
`endif

    assign w_last = (r_bit_idx == 5'(WIDTH - 1));

    // Next-value shifts; written generically so WIDTH=1 needs no special slicing.
    always_comb begin
        w_a_next                 = r_a >> 1;
        w_b_next                 = r_b >> 1;
        w_result_next            = r_result >> 1;
        w_result_next[WIDTH-1]   = i_fa_sum;
    end

    // Sequencer FSM with all datapath registers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= 1'b0;
            r_fa_a      <= 1'b0;
            r_fa_b      <= 1'b0;
            r_fa_cin    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_bit_idx   <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a         <= i_op_a;
                        r_b         <= i_op_b;
                        r_c         <= i_cin_init;
                        r_fa_a      <= i_op_a[0];
                        r_fa_b      <= i_op_b[0];
                        r_fa_cin    <= i_cin_init;
                        r_result    <= '0;
                        r_carry_out <= 1'b0;
                        r_bit_idx   <= 5'd0;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_step) begin
                        r_a       <= w_a_next;
                        r_b       <= w_b_next;
                        r_c       <= i_fa_cout;
                        r_result  <= w_result_next;
                        r_bit_idx <= r_bit_idx + 5'd1;
                        if (w_last) begin
                            // Adder inputs go quiet as soon as RUN ends.
                            r_carry_out <= i_fa_cout;
                            r_fa_a      <= 1'b0;
                            r_fa_b      <= 1'b0;
                            r_fa_cin    <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_fa_a   <= w_a_next[0];
                            r_fa_b   <= w_b_next[0];
                            r_fa_cin <= i_fa_cout;
                        end
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_fa_a      = r_fa_a;
    assign o_fa_b      = r_fa_b;
    assign o_fa_cin    = r_fa_cin;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_result    = r_result;
    assign o_carry_out = r_carry_out;
    assign o_bit_idx   = r_bit_idx;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq: WIDTH=8 and WIDTH=1 instances, each with a behavioural full adder.
module tb_serial_add_seq;
`ifdef SERIAL_ADD_TICK_EN
    localparam int TD = 4;
`else
    localparam int TD = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, cin;
    logic [7:0] op_a, op_b;
    logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic       busy, done, carry_out;
    logic [7:0] result;
    logic [4:0] bit_idx;

    logic       start1, cin1;
    logic [0:0] op_a1, op_b1, result1;
    logic       fa1_a, fa1_b, fa1_cin, fa1_sum, fa1_cout;
    logic       busy1, done1, carry1;
    logic [4:0] idx1;

    int checks = 0;
    int errors = 0;

    assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
    assign fa1_sum  = fa1_a ^ fa1_b ^ fa1_cin;
    assign fa1_cout = (fa1_a & fa1_b) | (fa1_a & fa1_cin) | (fa1_b & fa1_cin);

    serial_add_seq #(.WIDTH(8), .TICK_DIV(24'(TD))) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op_a(op_a), .i_op_b(op_b),
        .i_cin_init(cin), .o_fa_a(fa_a), .o_fa_b(fa_b), .o_fa_cin(fa_cin),
        .i_fa_sum(fa_sum), .i_fa_cout(fa_cout), .o_busy(busy), .o_done(done),
        .o_result(result), .o_carry_out(carry_out), .o_bit_idx(bit_idx)
    );

    serial_add_seq #(.WIDTH(1), .TICK_DIV(24'(TD))) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_op_a(op_a1), .i_op_b(op_b1),
        .i_cin_init(cin1), .o_fa_a(fa1_a), .o_fa_b(fa1_b), .o_fa_cin(fa1_cin),
        .i_fa_sum(fa1_sum), .i_fa_cout(fa1_cout), .o_busy(busy1), .o_done(done1),
        .o_result(result1), .o_carry_out(carry1), .o_bit_idx(idx1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accepting edge; returns edges until done and busy-high samples.
    task automatic wait8(output int cyc, output int nbusy);
        bit seen;
        seen  = 1'b0;
        cyc   = 0;
        nbusy = busy ? 1 : 0;
        while (!seen && cyc < 8 * TD + 10) begin
            tick();
            cyc++;
            if (done) seen = 1'b1;
            else if (busy) nbusy++;
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] er, input logic ec);
        int cyc, nbusy;
        op_a = a; op_b = b; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_e0"}, busy, 1);
        chk({tag, "_fa_a_e0"}, fa_a, a[0]);
        chk({tag, "_fa_b_e0"}, fa_b, b[0]);
        chk({tag, "_fa_cin_e0"}, fa_cin, c);
        wait8(cyc, nbusy);
        chk({tag, "_latency"}, cyc, 8 * TD);
        chk({tag, "_busy_cycles"}, nbusy, 8 * TD);
        chk({tag, "_result"}, result, er);
        chk({tag, "_carry"}, carry_out, ec);
        chk({tag, "_bit_idx"}, bit_idx, 8);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_fa_done"}, {fa_a, fa_b, fa_cin}, 0);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_result_held"}, result, er);
        chk({tag, "_bit_idx_held"}, bit_idx, 8);
    endtask

    initial begin
        int cyc, nbusy, ndone;
        rst = 1'b1; start = 1'b0; cin = 1'b0; op_a = 8'h00; op_b = 8'h00;
        start1 = 1'b0; cin1 = 1'b0; op_a1 = 1'b0; op_b1 = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_bit_idx", bit_idx, 0);
        chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);
        rst = 1'b0;
        tick();

        run8("add05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
        run8("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run8("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

        // start held high with changing operands through RUN and DONE
        op_a = 8'h21; op_b = 8'h13; cin = 1'b0; start = 1'b1;
        tick();
        ndone = 0;
        for (int i = 1; i <= 8 * TD + 1; i++) begin
            op_a = 8'(i) ^ 8'hC3;
            op_b = ~op_a;
            cin  = 1'b1;
            tick();
            if (done) ndone++;
        end
        chk("ign_done_count", ndone, 1);
        chk("ign_result", result, 8'h34);
        chk("ign_carry", carry_out, 0);
        chk("ign_idle_busy", busy, 0);
        op_a = 8'h0F; op_b = 8'h01; cin = 1'b0;
        tick();
        start = 1'b0;
        chk("ign_accept_busy", busy, 1);
        chk("ign_accept_clear", result, 0);
        chk("ign_accept_idx", bit_idx, 0);
        wait8(cyc, nbusy);
        chk("ign2_latency", cyc, 8 * TD);
        chk("ign2_result", result, 8'h10);
        tick();

        // reset on the edge after the third step
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3 * TD) tick();
        chk("mid_idx3", bit_idx, 3);
        chk("mid_partial", result, 8'hE0);
        rst = 1'b1; start = 1'b1; op_a = 8'h77;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_carry", carry_out, 0);
        chk("mid_rst_idx", bit_idx, 0);
        chk("mid_rst_fa", {fa_a, fa_b, fa_cin}, 0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("mid_rst_start_ignored", busy, 0);
        run8("after_rst_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // WIDTH=1 boundary
        op_a1 = 1'b1; op_b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("w1_busy", busy1, 1);
        chk("w1_fa", {fa1_a, fa1_b, fa1_cin}, 3'b111);
        cyc = 0;
        while (!done1 && cyc < TD + 10) begin
            tick();
            cyc++;
        end
        chk("w1_latency", cyc, TD);
        chk("w1_result", result1, 1);
        chk("w1_carry", carry1, 1);
        chk("w1_idx", idx1, 1);
        chk("w1_busy_done", busy1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial adder sequencer sitting directly in front of the single-bit full adder on the TinyTapeout top level. It latches two WIDTH-bit operands and an initial carry. It then presents one operand bit pair plus the running carry to the full adder per step, LSB first. It captures the returned sum and carry bits into a result register and pulses `done` when all WIDTH bits have been added.

## Interface
- `WIDTH`, 8: operand/result width in bits; legal range 1..16.
- `TICK_DIV`, 24'd10_000_000: clock cycles per step when `SERIAL_ADD_TICK_EN` is defined; legal minimum 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a new addition; sampled only in IDLE.
- `op_a` in WIDTH: operand A, latched on accepted `start`.
- `op_b` in WIDTH: operand B, latched on accepted `start`.
- `cin_init` in 1: initial carry, latched on accepted `start`.
- `fa_a` out 1: to full adder `a`.
- `fa_b` out 1: to full adder `b`.
- `fa_cin` out 1: to full adder `carry_in`.
- `fa_sum` in 1: from full adder `c` (sum).
- `fa_cout` in 1: from full adder `carry_out`.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse in DONE.
- `result` out WIDTH: sum; valid from DONE and held until next accepted `start`.
- `carry_out` out 1: final carry; same validity as `result`.
- `bit_idx` out 5: number of steps completed in the current operation.

## Operation
- States:
  - IDLE: `start`=1 latches `op_a`/`op_b` into shift registers A/B and `cin_init` into carry register C. Clears `bit_idx`, the tick counter and `result`, then goes to RUN.
  - RUN: performs steps. The WIDTH-th step goes to DONE.
  - DONE: lasts one cycle, then unconditionally returns to IDLE.
- Full-adder drive:
  - In RUN, `fa_a`=A[0], `fa_b`=B[0], `fa_cin`=C, all direct from registers, with no combinational path from `fa_sum`/`fa_cout`.
  - In IDLE and DONE all three drive 0.
- Each step, on a single edge:
  - `result` <= {`fa_sum`, `result`[WIDTH-1:1]}.
  - C <= `fa_cout`.
  - A and B shift right with 0 fill.
  - `bit_idx` increments.
- On the final step, `carry_out` <= `fa_cout`.
- After WIDTH steps, `result`[i] = sum bit i. The arithmetic is `{carry_out,result}` = `op_a` + `op_b` + `cin_init`, modulo 2^(WIDTH+1).
- `start` in RUN or DONE is ignored. It is not queued.
- Operand inputs are sampled only at the accepting edge; later changes have no effect.
- `rst` overrides everything, including mid-RUN: state IDLE, all registers and outputs 0.
- `start` asserted together with `rst` is ignored.
- `bit_idx` holds at WIDTH through DONE and IDLE until the next accepted `start`.

## Timing
- Reset value of every output is 0: `fa_a`, `fa_b`, `fa_cin`, `busy`, `done`, `result`, `carry_out`, `bit_idx`.
- Let edge E0 accept `start`.
- Without the tick feature:
  - Steps occur at edges E1..E_WIDTH.
  - `busy` is high for exactly WIDTH cycles, between E0 and E_WIDTH.
  - `done` is high between E_WIDTH and E_WIDTH+1.
  - Start-to-done latency is WIDTH edges.
  - The next `start` is accepted at E_WIDTH+2 at the earliest.
- With the tick feature:
  - The tick counter runs 0..TICK_DIV-1 in RUN; a step occurs on an edge where the counter is TICK_DIV-1, which then wraps to 0.
  - Step k occurs at edge E(k·TICK_DIV).
  - `done` follows E(WIDTH·TICK_DIV).
  - With TICK_DIV=1 the timing is identical to the no-tick build.
- The full adder is combinational. `fa_sum`/`fa_cout` are sampled on the same edge that shifts A/B/C.

## Configuration
- `SERIAL_ADD_TICK_EN` defined: the tick counter (24-bit) is compiled in, giving one step per TICK_DIV cycles so the board LEDs/segments visibly walk through each bit.
- Not defined: there is no counter, one step is taken per RUN cycle, and TICK_DIV is ignored.

## Test plan
- No tick, WIDTH=8: `op_a`=8'h05, `op_b`=8'h03, `cin_init`=0, `start` pulse -> `busy` high for 8 cycles; `done` for 1 cycle at E8; `result`=8'h08, `carry_out`=0, `bit_idx`=8.
- Wrap: 8'hFF + 8'h01, `cin_init`=0 -> `result`=8'h00, `carry_out`=1. Also 8'h00 + 8'h00 with `cin_init`=1 -> `result`=8'h01, `carry_out`=0.
- Ignored start: `start` re-asserted every cycle during RUN and DONE with new operands -> result matches the first operands only; exactly one `done` pulse; next operation accepted at E10.
- Mid-operation reset: `rst` at the edge after step 3 of 8'hAA + 8'h55 -> all outputs 0, IDLE next cycle. A following `start` with 8'h12 + 8'h34 gives `result`=8'h46, `carry_out`=0.
- Tick build, TICK_DIV=4, WIDTH=8: 8'h80 + 8'h80 -> `result`=8'h00, `carry_out`=1; `done` at E32; `bit_idx` increments only every 4th edge.
- Boundary WIDTH=1: 1+1, `cin_init`=1 -> `result`=1, `carry_out`=1, `done` at E1.
